// File: rtl/bp_pkg.sv
// Shared branch-predictor types: 2-bit counter encodings, in-flight queue entry, counter update rule.
package bp_pkg;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    // Widest table index any instance may use; narrower instances zero-extend.
    localparam int BP_IDX_MAX_W = 16;

    typedef struct packed {
        logic [BP_IDX_MAX_W-1:0] idx;
        logic                    pred;
    } q_entry_t;

    // Correct prediction snaps to the strong state; a miss steps one state toward the outcome.
    function automatic logic [1:0] ctr_next(input logic [1:0] ctr,
                                            input logic       taken_actual,
                                            input logic       pred);
        if (pred == taken_actual)
            return taken_actual ? ST : SNT;
        if (pred)
            return (ctr == SNT) ? SNT : ctr - 2'd1;
        return (ctr == ST) ? ST : ctr + 2'd1;
    endfunction

endpackage

// File: rtl/bp_inflight_fifo.sv
// In-order queue of outstanding predictions; 1-cycle write-to-read, head readable combinationally.
// Push ignored when full, pop ignored when empty; clear empties it and beats a same-cycle push or pop.
module bp_inflight_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  q_entry_t                   push_dat,
    input  logic                       pop,
    output q_entry_t                   pop_dat,
    input  logic                       clear,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    q_entry_t        mem_q [DEPTH];
    q_entry_t        mem_d [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            push_ok, pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign pop_dat = mem_q[rd_ptr_q];
    assign push_ok = push && !full && !clear;
    assign pop_ok  = pop && !empty && !clear;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = push_dat;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop_ok)
                rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload needs no reset: it is only read behind a non-zero count.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/bht_ctrl.sv
// Branch-history-table controller: combinational lookup, update and registered mispredict/flush 1 cycle after resolve.
// Fetch is backpressured by br_ready (registered queue-full); stall freezes all state.
module bht_ctrl
    import bp_pkg::*;
#(
    parameter int IDX_W   = 4,
    parameter int Q_DEPTH = 4,
    parameter int CNT_W   = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       stall,
    input  logic                       br_valid,
    input  logic [31:0]                br_pc,
    output logic                       br_ready,
    output logic                       br_taken,
    input  logic                       res_valid,
    input  logic                       res_taken,
    output logic                       mispredict,
    output logic                       flush,
    output logic [$clog2(Q_DEPTH):0]   outstanding,
    output logic                       err_underflow,
    output logic [CNT_W-1:0]           br_cnt,
    output logic [CNT_W-1:0]           miss_cnt
);
    localparam int N = 2 ** IDX_W;

    logic [1:0]       ctr_q [N];
    logic [1:0]       ctr_d [N];
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;
    logic             mispredict_q, mispredict_d;
    logic             err_q, err_d;

    logic [IDX_W-1:0] idx, hidx;
    q_entry_t         push_dat, head;
    logic             full, empty, push, pop;
    logic             unused_bits;

    assign idx      = br_pc[IDX_W+1:2];
    assign br_taken = ctr_q[idx][1];
    assign br_ready = !full;

    // While flush is high the queue is being cleared, so fetch and execute are both ignored.
    assign push     = br_valid && !full && !stall && !mispredict_q;
    assign pop      = res_valid && !empty && !stall && !mispredict_q;
    assign push_dat = '{idx: BP_IDX_MAX_W'(idx), pred: br_taken};
    assign hidx     = head.idx[IDX_W-1:0];

    assign unused_bits = &{1'b0, br_pc[31:IDX_W+2], br_pc[1:0], head.idx[BP_IDX_MAX_W-1:IDX_W]};

    bp_inflight_fifo #(.DEPTH(Q_DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .pop_dat  (head),
        .clear    (mispredict_q),
        .full     (full),
        .empty    (empty),
        .count    (outstanding)
    );

    always_comb begin
        ctr_d        = ctr_q;
        br_cnt_d     = br_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        mispredict_d = 1'b0;
        err_d        = err_q | (res_valid && empty && !stall && !mispredict_q);
        if (pop) begin
            ctr_d[hidx]  = ctr_next(ctr_q[hidx], res_taken, head.pred);
            mispredict_d = (head.pred != res_taken);
            if (br_cnt_q != '1)
                br_cnt_d = br_cnt_q + CNT_W'(1);
            if (mispredict_d && (miss_cnt_q != '1))
                miss_cnt_d = miss_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++)
                ctr_q[i] <= WNT;
            br_cnt_q     <= '0;
            miss_cnt_q   <= '0;
            mispredict_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            ctr_q        <= ctr_d;
            br_cnt_q     <= br_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
            mispredict_q <= mispredict_d;
            err_q        <= err_d;
        end
    end

    assign mispredict    = mispredict_q;
    assign flush         = mispredict_q;
    assign err_underflow = err_q;
    assign br_cnt        = br_cnt_q;
    assign miss_cnt      = miss_cnt_q;

endmodule

// File: tb/tb_bht_ctrl.sv
// Bench for bht_ctrl: vector table with hand-derived expectations plus a prediction scoreboard.
module tb_bht_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, br_valid, res_valid, res_taken;
    logic [31:0] br_pc;
    logic        br_ready, br_taken, mispredict, flush, err_underflow;
    logic [2:0]  outstanding;
    logic [15:0] br_cnt, miss_cnt;

    bht_ctrl #(.IDX_W(4), .Q_DEPTH(4), .CNT_W(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .br_valid      (br_valid),
        .br_pc         (br_pc),
        .br_ready      (br_ready),
        .br_taken      (br_taken),
        .res_valid     (res_valid),
        .res_taken     (res_taken),
        .mispredict    (mispredict),
        .flush         (flush),
        .outstanding   (outstanding),
        .err_underflow (err_underflow),
        .br_cnt        (br_cnt),
        .miss_cnt      (miss_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        bv;
        logic [31:0] pc;
        logic        rv;
        logic        rt;
        logic        st;
        logic        e_tk;
        logic        e_rdy;
        int          e_out;
        int          e_br;
        int          e_miss;
        logic        e_err;
    } vec_t;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic bv, input logic [31:0] pc, input logic rv,
                                input logic rt, input logic st, input logic e_tk,
                                input logic e_rdy, input int e_out, input int e_br,
                                input int e_miss, input logic e_err);
        vec_t v;
        v.bv = bv; v.pc = pc; v.rv = rv; v.rt = rt; v.st = st;
        v.e_tk = e_tk; v.e_rdy = e_rdy; v.e_out = e_out;
        v.e_br = e_br; v.e_miss = e_miss; v.e_err = e_err;
        return v;
    endfunction

    vec_t vecs [41];
    bit   sb_q [$];

    initial begin
        bit flush_exp;
        bit mis_exp;
        bit push_acc, pop_acc, p;

        // bv, pc, rv, rt, stall | taken, ready, outstanding(pre-edge) | br_cnt, miss_cnt, err (post-edge)
        vecs[0]  = mk(1, 32'h40, 0, 0, 0,  0, 1, 0,  0, 0, 0);
        vecs[1]  = mk(0, 32'h40, 1, 1, 0,  0, 1, 1,  1, 1, 0);
        vecs[2]  = mk(0, 32'h40, 0, 0, 0,  1, 1, 0,  1, 1, 0);
        vecs[3]  = mk(1, 32'h40, 0, 0, 0,  1, 1, 0,  1, 1, 0);
        vecs[4]  = mk(0, 32'h40, 1, 1, 0,  1, 1, 1,  2, 1, 0);
        vecs[5]  = mk(1, 32'h40, 0, 0, 0,  1, 1, 0,  2, 1, 0);
        vecs[6]  = mk(0, 32'h40, 1, 0, 0,  1, 1, 1,  3, 2, 0);
        vecs[7]  = mk(0, 32'h40, 0, 0, 0,  1, 1, 0,  3, 2, 0);
        vecs[8]  = mk(1, 32'h44, 0, 0, 0,  0, 1, 0,  3, 2, 0);
        vecs[9]  = mk(1, 32'h48, 0, 0, 0,  0, 1, 1,  3, 2, 0);
        vecs[10] = mk(1, 32'h4C, 0, 0, 0,  0, 1, 2,  3, 2, 0);
        vecs[11] = mk(1, 32'h50, 0, 0, 0,  0, 1, 3,  3, 2, 0);
        vecs[12] = mk(1, 32'h54, 0, 0, 0,  0, 0, 4,  3, 2, 0);
        vecs[13] = mk(1, 32'h54, 1, 0, 0,  0, 0, 4,  4, 2, 0);
        vecs[14] = mk(1, 32'h54, 0, 0, 0,  0, 1, 3,  4, 2, 0);
        vecs[15] = mk(0, 32'h40, 1, 0, 0,  1, 0, 4,  5, 2, 0);
        vecs[16] = mk(0, 32'h40, 1, 0, 0,  1, 1, 3,  6, 2, 0);
        vecs[17] = mk(0, 32'h40, 1, 0, 0,  1, 1, 2,  7, 2, 0);
        vecs[18] = mk(0, 32'h40, 1, 0, 0,  1, 1, 1,  8, 2, 0);
        vecs[19] = mk(1, 32'h58, 0, 0, 0,  0, 1, 0,  8, 2, 0);
        vecs[20] = mk(1, 32'h5C, 0, 0, 0,  0, 1, 1,  8, 2, 0);
        vecs[21] = mk(1, 32'h60, 0, 0, 0,  0, 1, 2,  8, 2, 0);
        vecs[22] = mk(0, 32'h60, 1, 1, 0,  0, 1, 3,  9, 3, 0);
        vecs[23] = mk(1, 32'h64, 0, 0, 0,  0, 1, 2,  9, 3, 0);
        vecs[24] = mk(0, 32'h5C, 0, 0, 0,  0, 1, 0,  9, 3, 0);
        vecs[25] = mk(0, 32'h60, 0, 0, 0,  0, 1, 0,  9, 3, 0);
        vecs[26] = mk(0, 32'h58, 0, 0, 0,  1, 1, 0,  9, 3, 0);
        vecs[27] = mk(0, 32'h40, 1, 1, 0,  1, 1, 0,  9, 3, 1);
        vecs[28] = mk(0, 32'h40, 0, 0, 0,  1, 1, 0,  9, 3, 1);
        vecs[29] = mk(1, 32'h4C, 0, 0, 0,  0, 1, 0,  9, 3, 1);
        vecs[30] = mk(1, 32'h4C, 1, 1, 0,  0, 1, 1, 10, 4, 1);
        vecs[31] = mk(0, 32'h4C, 0, 0, 0,  0, 1, 1, 10, 4, 1);
        vecs[32] = mk(1, 32'h4C, 0, 0, 0,  0, 1, 0, 10, 4, 1);
        vecs[33] = mk(1, 32'h4C, 1, 1, 0,  0, 1, 1, 11, 5, 1);
        vecs[34] = mk(0, 32'h4C, 0, 0, 0,  1, 1, 1, 11, 5, 1);
        vecs[35] = mk(1, 32'h40, 0, 0, 0,  1, 1, 0, 11, 5, 1);
        vecs[36] = mk(1, 32'h44, 1, 0, 1,  0, 1, 1, 11, 5, 1);
        vecs[37] = mk(1, 32'h44, 1, 0, 1,  0, 1, 1, 11, 5, 1);
        vecs[38] = mk(0, 32'h40, 0, 0, 0,  1, 1, 1, 11, 5, 1);
        vecs[39] = mk(0, 32'h40, 1, 0, 0,  1, 1, 1, 12, 6, 1);
        vecs[40] = mk(0, 32'h40, 0, 0, 1,  0, 1, 0, 12, 6, 1);

        rst_n = 1'b0; stall = 1'b0; br_valid = 1'b0; br_pc = 32'h40;
        res_valid = 1'b0; res_taken = 1'b0;
        #12;
        rst_n = 1'b1;
        #1;
        check("reset br_ready",    int'(br_ready), 1);
        check("reset br_taken",    int'(br_taken), 0);
        check("reset mispredict",  int'(mispredict), 0);
        check("reset flush",       int'(flush), 0);
        check("reset outstanding", int'(outstanding), 0);
        check("reset err",         int'(err_underflow), 0);
        check("reset br_cnt",      int'(br_cnt), 0);
        check("reset miss_cnt",    int'(miss_cnt), 0);
        @(posedge clk); #1;

        flush_exp = 1'b0;
        for (int i = 0; i < 41; i++) begin
            br_valid = vecs[i].bv; br_pc = vecs[i].pc; res_valid = vecs[i].rv;
            res_taken = vecs[i].rt; stall = vecs[i].st;
            #1;
            check($sformatf("v%0d br_taken", i),    int'(br_taken), int'(vecs[i].e_tk));
            check($sformatf("v%0d br_ready", i),    int'(br_ready), int'(vecs[i].e_rdy));
            check($sformatf("v%0d outstanding", i), int'(outstanding), vecs[i].e_out);

            push_acc = vecs[i].bv && vecs[i].e_rdy && !vecs[i].st && !flush_exp;
            pop_acc  = vecs[i].rv && !vecs[i].st && !flush_exp && (sb_q.size() > 0);
            mis_exp  = 1'b0;
            if (flush_exp) begin
                sb_q.delete();
            end else begin
                if (pop_acc) begin
                    p = sb_q.pop_front();
                    mis_exp = (p != vecs[i].rt);
                end
                if (push_acc)
                    sb_q.push_back(vecs[i].e_tk);
            end

            @(posedge clk); #1;
            check($sformatf("v%0d mispredict", i), int'(mispredict), int'(mis_exp));
            check($sformatf("v%0d flush", i),      int'(flush), int'(mis_exp));
            check($sformatf("v%0d occupancy", i),  int'(outstanding), sb_q.size());
            check($sformatf("v%0d br_cnt", i),     int'(br_cnt), vecs[i].e_br);
            check($sformatf("v%0d miss_cnt", i),   int'(miss_cnt), vecs[i].e_miss);
            check($sformatf("v%0d err", i),        int'(err_underflow), int'(vecs[i].e_err));
            flush_exp = mis_exp;
        end

        // Async reset with three in flight and a flush pending.
        stall = 1'b0; res_valid = 1'b0;
        br_valid = 1'b1;
        br_pc = 32'h44; @(posedge clk); #1;
        br_pc = 32'h48; @(posedge clk); #1;
        br_pc = 32'h4C; @(posedge clk); #1;
        br_pc = 32'h50; res_valid = 1'b1; res_taken = 1'b1;
        @(posedge clk); #1;
        br_valid = 1'b0; res_valid = 1'b0;
        check("pre-reset outstanding", int'(outstanding), 3);
        check("pre-reset mispredict",  int'(mispredict), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async outstanding", int'(outstanding), 0);
        check("async mispredict",  int'(mispredict), 0);
        check("async flush",       int'(flush), 0);
        check("async br_cnt",      int'(br_cnt), 0);
        check("async miss_cnt",    int'(miss_cnt), 0);
        check("async err",         int'(err_underflow), 0);
        check("async br_ready",    int'(br_ready), 1);
        for (int k = 0; k < 16; k++) begin
            br_pc = 32'h40 + 32'(4 * k);
            #1;
            check($sformatf("async ctr%0d taken", k), int'(br_taken), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post-reset outstanding", int'(outstanding), 0);
        check("post-reset mispredict",  int'(mispredict), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bht_ctrl.md
# bht_ctrl

Branch-history-table controller. It owns a table of 2-bit saturating predictors and serves a prediction to fetch each time a branch is decoded. It keeps each outstanding prediction in an in-order in-flight queue. When execute resolves a branch, it retires the oldest queue entry, updates that entry's predictor, and raises a registered mispredict/flush to the pipeline.

## Interface
- `IDX_W`, default 4: table index width; `2**IDX_W` predictor entries.
- `Q_DEPTH`, default 4: in-flight queue depth; power of two, ≥2.
- `CNT_W`, default 16: width of the statistics counters.
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `stall` in 1: pipeline stall; when 1, no push, pop, table update or statistics update.
- `br_valid` in 1: fetch presents a decoded branch this cycle.
- `br_pc` in 32: PC of that branch.
- `br_ready` out 1: queue can accept; equals `!full`.
- `br_taken` out 1: prediction for `br_pc`; combinational, equals `ctr[idx][1]`.
- `res_valid` in 1: execute resolves the oldest outstanding branch.
- `res_taken` in 1: actual outcome of that branch.
- `mispredict` out 1: registered one-cycle pulse; predicted ≠ actual.
- `flush` out 1: registered; equals `mispredict`, drives wrong-path squash.
- `outstanding` out `$clog2(Q_DEPTH)+1`: current queue occupancy.
- `err_underflow` out 1: sticky; a resolve arrived with the queue empty.
- `br_cnt` out `CNT_W`: count of resolved branches; saturating.
- `miss_cnt` out `CNT_W`: count of mispredicts; saturating.

## Operation
- **Index:** `idx = br_pc[IDX_W+1:2]`.
- **Push:** occurs when `br_valid && br_ready && !stall && !flush`. Stores `{idx, br_taken}` at the tail.
- **Pop:** occurs when `res_valid && !stall && outstanding != 0`. Reads the head entry `{hidx, hpred}`.
- **Mispredict on pop:** `mis = (hpred != res_taken)`.
- **Counter update on pop**, applied to `ctr[hidx]`:
  - Correct prediction: set to strong (`11` if taken, `00` if not taken).
  - Mispredict with predicted taken: decrement by 1.
  - Mispredict with predicted not-taken: increment by 1.
  - Never wraps: `00`→`01`, `01`→`10`, `10`→`01`, `11`→`10` as the mispredict steps.
- **Flush:** on the cycle after a mispredicting pop, `mispredict = flush = 1`. In that cycle:
  - The queue is emptied (`outstanding` ← 0).
  - Any same-cycle push is dropped.
  - Any same-cycle `res_valid` is ignored; the pipeline must not present one.
- **Simultaneous push and pop:** both take effect; `outstanding` is unchanged.
- **Lookup/update same index, same cycle:** the lookup returns the pre-update counter value. No bypass.
- **Full queue:** `br_ready = 0`. A pop in the same cycle does not re-enable `br_ready` combinationally; it is visible next cycle.
- **Empty queue:** a `res_valid` is ignored, sets `err_underflow` (cleared only by reset), and does not change the counters.
- **Statistics:** `br_cnt` increments on each pop; `miss_cnt` increments on each mispredicting pop. Both hold at all-ones.
- **Stall:** freezes all state. `br_taken` and `br_ready` still reflect the current state. A pending `mispredict` pulse still deasserts after one cycle.

## Timing
- **Reset values:** all `ctr` = `01` (weakly not-taken); queue empty; `br_ready = 1`; `br_taken = 0`; `mispredict = flush = 0`; `outstanding = 0`; `err_underflow = 0`; `br_cnt = miss_cnt = 0`.
- **Reset mid-operation:** takes effect asynchronously. The queue and all in-flight predictions are discarded, and any pending flush is cancelled.
- **Latency:**
  - `br_taken`: 0 cycles (combinational).
  - Counter update: visible to lookups the cycle after the pop.
  - `mispredict`/`flush`: 1 cycle after the pop.
- `outstanding` updates on the clock edge.

## Structure
- **Shared package `bp_pkg`:**
  - 2-bit counter state constants `SNT=00`, `WNT=01`, `WT=10`, `ST=11`.
  - Queue entry typedef `{idx, pred}`.
  - Helper function `ctr_next(ctr, taken_actual, pred)`.
- **Sub-module `bp_inflight_fifo`:** a synchronous FIFO with push, pop, clear, full/empty and count. It clears on flush, with clear taking priority over push.
- The counter table lives in `bht_ctrl` as a flop array, since it needs async reset of every entry.

## Test plan
- **Reset, then push:** after reset, push `br_pc=0x40` (idx 0). Required: `br_taken=0`, `outstanding=1`. Resolve with `res_taken=1`. Required: `mispredict=1` for exactly one cycle; `ctr[0]=10`; next lookup of `0x40` gives `br_taken=1`.
- **Correct-prediction path:** starting from `ctr[0]=10`, push `0x40` and resolve taken. Required: no mispredict, `ctr[0]=11`. Then push and resolve not-taken. Required: `ctr[0]=10`, `mispredict=1`, `miss_cnt=2`, `br_cnt=3`.
- **Full queue:** push 4 distinct PCs with no resolve. Required: `br_ready=0`, `outstanding=4`, and a 5th push is ignored. One pop, then `br_ready=1` on the following cycle.
- **Flush:** push A, B, C, all predicted not-taken, then resolve A as taken. Required: next cycle `flush=1`; a push presented that cycle is dropped; `outstanding=0`; B's and C's counters are unchanged.
- **Underflow and simultaneous events:**
  - Empty queue plus `res_valid`: `err_underflow=1` stays set; counters unchanged.
  - Simultaneous push of idx 3 and pop of idx 3: the lookup returns the old counter and `outstanding` is unchanged.
- **Stall and async reset:**
  - Holding `stall=1` with `br_valid` and `res_valid` both asserted changes no state.
  - Asserting `rst_n=0` mid-cycle with 3 outstanding immediately gives `outstanding=0` and all counters `01`.
